// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner. Steps one digit per rising edge
// of the divided clk_N and latches the displayed word once per frame.
module seg7_scan #(
    parameter bit BLANK_LZ      = 1'b0,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_N,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam logic [7:0] AN_OFF = AN_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic        clkNPrev_q, clkNPrev_d;
    logic        armed_q, armed_d;
    logic        started_q, started_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] frame_q, frame_d;
    logic [7:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;

    logic        tick;
    logic        blank;
    logic [31:0] frameShift;
    logic [3:0]  nibble;
    logic [7:0]  anOneHot;

    function automatic logic [6:0] hexSeg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // armed_q blocks a tick until clk_N has been seen low after reset, so a
    // clk_N held high across reset release is not mistaken for a rising edge.
    always_comb begin
        clkNPrev_d = clk_N;
        armed_d    = armed_q | ~clk_N;
        started_d  = started_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        an_d       = an_q;
        seg_d      = seg_q;
        tick       = clk_N & ~clkNPrev_q & armed_q;
        frameShift = 32'd0;
        nibble     = 4'd0;
        blank      = 1'b0;
        anOneHot   = 8'd0;

        if (tick) begin
            started_d = 1'b1;
            if (!started_q) begin
                idx_d   = 3'd0;
                frame_d = data;
            end else begin
                idx_d = idx_q + 3'd1;
                if (idx_d == 3'd0) begin
                    frame_d = data;
                end
            end
            frameShift = frame_d >> {idx_d, 2'b00};
            nibble     = frameShift[3:0];
            blank      = BLANK_LZ && (idx_d != 3'd0) && (frameShift == 32'd0);
            seg_d      = blank ? 8'hFF : {~dp[idx_d], hexSeg(nibble)};
            anOneHot   = 8'd1 << idx_d;
            an_d       = AN_ACTIVE_LOW ? ~anOneHot : anOneHot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clkNPrev_q <= 1'b0;
            armed_q    <= 1'b0;
            started_q  <= 1'b0;
            idx_q      <= 3'd0;
            frame_q    <= 32'd0;
            an_q       <= AN_OFF;
            seg_q      <= 8'hFF;
        end else begin
            clkNPrev_q <= clkNPrev_d;
            armed_q    <= armed_d;
            started_q  <= started_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: three parameter variants share stimulus and are compared
// every cycle against a digit-level reference model, plus directed spot checks.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        clkN;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  an0, seg0, an1, seg1, an2, seg2;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] curData;
    logic [7:0]  curDp;

    // Reference model: which digit is lit, the latched frame, expected segments.
    bit          mPrev;
    bit          mStarted;
    bit          mOn;
    int          mDigit;
    logic [31:0] mFrame;
    logic [7:0]  mSegPlain;
    logic [7:0]  mSegBlank;

    logic [7:0] hexTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] firstSeg [3]  = '{8'h80, 8'hF8, 8'h82};
    logic [7:0] firstAn  [3]  = '{8'hFE, 8'hFD, 8'hFB};
    logic [7:0] beefSeg  [8]  = '{8'h8E, 8'h86, 8'h86, 8'h83, 8'hA1, 8'h88, 8'h86, 8'hA1};
    logic [7:0] blankSeg [8]  = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    always #5 clk = ~clk;

    seg7_scan #(.BLANK_LZ(1'b0), .AN_ACTIVE_LOW(1'b1)) u0 (
        .clk(clk), .rst(rst), .clk_N(clkN), .data(data), .dp(dp), .an(an0), .seg(seg0));
    seg7_scan #(.BLANK_LZ(1'b1), .AN_ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .rst(rst), .clk_N(clkN), .data(data), .dp(dp), .an(an1), .seg(seg1));
    seg7_scan #(.BLANK_LZ(1'b0), .AN_ACTIVE_LOW(1'b0)) u2 (
        .clk(clk), .rst(rst), .clk_N(clkN), .data(data), .dp(dp), .an(an2), .seg(seg2));

    task automatic compare(input string tag, input string what,
                           input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s %s observed=%h expected=%h", tag, what, observed, expected);
        end
    endtask

    // Drives one clock of inputs and advances the model by what that edge should do.
    // A rising edge only counts once clk_N has been low since reset.
    task automatic applyStimulus(input logic r, input logic c,
                                 input logic [31:0] d, input logic [7:0] p);
        int nib;
        rst  = r;
        clkN = c;
        data = d;
        dp   = p;
        if (r) begin
            mPrev     = 1'b1;
            mStarted  = 1'b0;
            mOn       = 1'b0;
            mDigit    = 0;
            mFrame    = 32'd0;
            mSegPlain = 8'hFF;
            mSegBlank = 8'hFF;
        end else begin
            if (c && !mPrev) begin
                if (!mStarted) begin
                    mStarted = 1'b1;
                    mDigit   = 0;
                end else begin
                    mDigit = (mDigit + 1) % 8;
                end
                if (mDigit == 0) mFrame = d;
                mOn       = 1'b1;
                nib       = int'((mFrame >> (4 * mDigit)) & 32'hF);
                mSegPlain = hexTable[nib] & (p[mDigit] ? 8'h7F : 8'hFF);
                mSegBlank = (mDigit > 0 && (mFrame >> (4 * mDigit)) == 32'd0) ? 8'hFF : mSegPlain;
            end
            mPrev = c;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] expHigh;
        expHigh = mOn ? (8'd1 << mDigit) : 8'h00;
        compare(tag, "an0",  an0,  ~expHigh);
        compare(tag, "seg0", seg0, mSegPlain);
        compare(tag, "an1",  an1,  ~expHigh);
        compare(tag, "seg1", seg1, mSegBlank);
        compare(tag, "an2",  an2,  expHigh);
        compare(tag, "seg2", seg2, mSegPlain);
    endtask

    task automatic step(input logic c, input string tag);
        applyStimulus(1'b0, c, curData, curDp);
        checkOutput(tag);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, curData, curDp);
        applyStimulus(1'b1, 1'b0, curData, curDp);
        checkOutput("reset");
    endtask

    initial begin
        logic [7:0] expAn;
        logic       r;
        curData = 32'd0;
        curDp   = 8'd0;

        // Reset state, then the first three digits of 0x12345678.
        doReset();
        compare("reset", "an0", an0, 8'hFF);
        compare("reset", "seg0", seg0, 8'hFF);
        compare("reset", "an2", an2, 8'h00);
        curData = 32'h12345678;
        step(1'b0, "idle");
        step(1'b0, "idle");
        compare("preTick", "an0", an0, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, "first");
            compare("first", "an0", an0, firstAn[i]);
            compare("first", "seg0", seg0, firstSeg[i]);
            step(1'b0, "first");
        end

        // Full frame and wrap.
        doReset();
        curData = 32'hDEADBEEF;
        step(1'b0, "beef");
        for (int i = 0; i < 9; i++) begin
            step(1'b1, "beef");
            expAn = 8'd1 << (i % 8);
            compare("beef", "an0", an0, ~expAn);
            compare("beef", "seg0", seg0, beefSeg[i % 8]);
            step(1'b0, "beef");
        end

        // Data change mid-frame must not show until the wrap.
        doReset();
        curData = 32'h11111111;
        step(1'b0, "tear");
        for (int i = 0; i < 9; i++) begin
            if (i == 4) curData = 32'h22222222;
            step(1'b1, "tear");
            if (i >= 4 && i < 8) compare("tear", "seg0", seg0, 8'hF9);
            if (i == 8) begin
                compare("tearWrap", "seg0", seg0, 8'hA4);
                compare("tearWrap", "an0", an0, 8'hFE);
            end
            step(1'b0, "tear");
        end

        // Leading-zero blanking.
        doReset();
        curData = 32'h00000A05;
        step(1'b0, "blank");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, "blank");
            expAn = 8'd1 << i;
            compare("blank", "an1", an1, ~expAn);
            compare("blank", "seg1", seg1, blankSeg[i]);
            step(1'b0, "blank");
        end
        curData = 32'd0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, "blankZero");
            compare("blankZero", "seg1", seg1, (i == 0) ? 8'hC0 : 8'hFF);
            step(1'b0, "blankZero");
        end

        // Decimal point on digit 2 only.
        doReset();
        curData = 32'h33333333;
        curDp   = 8'h04;
        step(1'b0, "dp");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, "dp");
            compare("dp", "seg0", seg0, (i == 2) ? 8'h30 : 8'hB0);
            step(1'b0, "dp");
        end
        curDp = 8'h00;

        // Reset in the middle of a scan.
        doReset();
        curData = $urandom;
        step(1'b0, "midRst");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, "midRst");
            step(1'b0, "midRst");
        end
        applyStimulus(1'b1, 1'b0, curData, curDp);
        checkOutput("midRst");
        compare("midRst", "an0", an0, 8'hFF);
        compare("midRst", "seg0", seg0, 8'hFF);
        step(1'b0, "midRst");
        step(1'b1, "midRst");
        compare("midRstRestart", "an0", an0, 8'hFE);

        // clk_N held high across reset release.
        applyStimulus(1'b1, 1'b1, curData, curDp);
        applyStimulus(1'b1, 1'b1, curData, curDp);
        checkOutput("hiRst");
        for (int i = 0; i < 3; i++) step(1'b1, "hiRst");
        compare("hiRst", "an0", an0, 8'hFF);
        step(1'b0, "hiRst");
        step(1'b1, "hiRst");
        compare("hiRstEdge", "an0", an0, 8'hFE);

        // Reset coincident with a rising edge.
        step(1'b0, "coRst");
        step(1'b1, "coRst");
        step(1'b0, "coRst");
        applyStimulus(1'b1, 1'b1, curData, curDp);
        checkOutput("coRst");
        compare("coRst", "an0", an0, 8'hFF);
        step(1'b1, "coRst");
        compare("coRstHeld", "an0", an0, 8'hFF);
        step(1'b0, "coRst");
        step(1'b1, "coRst");
        compare("coRstEdge", "an0", an0, 8'hFE);

        // Long high pulse gives exactly one step.
        step(1'b0, "hold");
        for (int i = 0; i < 50; i++) step(1'b1, "hold");
        compare("hold", "an0", an0, 8'hFD);
        step(1'b0, "hold");

        // Randomised traffic including occasional resets.
        doReset();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            curData = $urandom;
            curDp   = 8'($urandom);
            applyStimulus(r, 1'($urandom_range(0, 1)), curData, curDp);
            checkOutput("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
